// File: rtl/morse_pkg.sv
// ============================================================================
// Module : morse_pkg
// Brief  : Shared tap encodings, sequencer state type and box geometry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

  // These encodings are shared with the draw block.
  localparam logic [1:0] TAP_NONE = 2'd0;
  localparam logic [1:0] TAP_DASH = 2'd1;
  localparam logic [1:0] TAP_DOT  = 2'd2;

  localparam logic [9:0] BOX_PITCH = 10'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_GAP    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/morse_debounce.sv
// ============================================================================
// Module : morse_debounce
// Brief  : Two-flop synchronizer followed by a stable-count debouncer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module morse_debounce #(
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new level is taken only after DEB_CYC consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_CYC - 16'd1) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign key_db = level_q;

endmodule

`default_nettype wire

// File: rtl/morse_tap_sequencer.sv
// ============================================================================
// Module : morse_tap_sequencer
// Brief  : Key timing to dot/dash letters, with raster-driven box/tap output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module morse_tap_sequencer
  import morse_pkg::*;
#(
  parameter logic [15:0] DEB_CYC = 16'd50000,
  parameter logic [23:0] DOT_MAX = 24'd2500000,
  parameter logic [23:0] GAP_CYC = 24'd7500000,
  parameter int unsigned MAX_SYM = 6,
  parameter logic [9:0]  BOX_X0  = 10'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       clear,
  input  logic [9:0] x,
  output logic [9:0] box_x,
  output logic [1:0] tap,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic [5:0] letter_code,
  output logic [2:0] letter_len,
  output logic       overflow
);

  localparam logic [2:0] C_MAX = 3'(MAX_SYM);

  logic        key_db;
  state_e      state_q, state_d;
  logic [23:0] press_q, press_d;
  logic [23:0] gap_q, gap_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  code_q, code_d;
  logic        ovf_q, ovf_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [1:0]  tap_q, tap_d;
  logic        w_is_dash;

  morse_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .key_db (key_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      press_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      box_x_q <= BOX_X0;
      tap_q   <= TAP_NONE;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      box_x_q <= box_x_d;
      tap_q   <= tap_d;
    end
  end

  assign w_is_dash = (press_q > DOT_MAX);

  always_comb begin
    state_d = state_q;
    press_d = press_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (key_db) begin
          state_d = ST_PRESS;
          press_d = '0;
        end
      end
      ST_PRESS: begin
        if (press_q != '1) press_d = press_q + 24'd1;
        if (!key_db) begin
          state_d = ST_GAP;
          gap_d   = '0;
          if (cnt_q == C_MAX) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (cnt_q == 3'(i)) code_d[i] = w_is_dash;
            end
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 24'd1;
        if (key_db) begin
          state_d = ST_PRESS;
          press_d = '0;
        end else if (gap_q == GAP_CYC - 24'd1) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // The key is deliberately ignored here; a held key restarts timing from IDLE.
        if (letter_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      code_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  logic [MAX_SYM-1:0] w_in_box;
  logic [9:0]         w_box_lo  [MAX_SYM];
  logic [1:0]         w_box_tap [MAX_SYM];

  for (genvar g = 0; g < MAX_SYM; g++) begin : g_box
    localparam logic [9:0] LO = BOX_X0 + 10'(g) * BOX_PITCH;
    localparam logic [9:0] HI = LO + BOX_PITCH;
    assign w_box_lo[g]  = LO;
    assign w_in_box[g]  = (x >= LO) && (x < HI);
    assign w_box_tap[g] = (3'(g) < cnt_q) ? (code_q[g] ? TAP_DASH : TAP_DOT) : TAP_NONE;
  end

  // Boxes are disjoint, so at most one comparator hits.
  always_comb begin
    box_x_d = BOX_X0;
    tap_d   = TAP_NONE;
    for (int i = 0; i < MAX_SYM; i++) begin
      if (w_in_box[i]) begin
        box_x_d = w_box_lo[i];
        tap_d   = w_box_tap[i];
      end
    end
  end

  assign box_x        = box_x_q;
  assign tap          = tap_q;
  assign letter_valid = (state_q == ST_COMMIT);
  assign letter_code  = code_q;
  assign letter_len   = cnt_q;
  assign overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_tap_sequencer.sv
// ============================================================================
// Module : tb_morse_tap_sequencer
// Brief  : Directed self-checking bench for morse_tap_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_morse_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       clear;
  logic [9:0] x;
  logic [9:0] box_x;
  logic [1:0] tap;
  logic       letter_valid;
  logic       letter_ready;
  logic [5:0] letter_code;
  logic [2:0] letter_len;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morse_tap_sequencer #(
    .DEB_CYC (16'd4),
    .DOT_MAX (24'd20),
    .GAP_CYC (24'd60)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .clear        (clear),
    .x            (x),
    .box_x        (box_x),
    .tap          (tap),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .letter_code  (letter_code),
    .letter_len   (letter_len),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    key_in = 1'b1;
    step(hi);
    key_in = 1'b0;
    step(lo);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!letter_valid && n < 300) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, letter_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    letter_ready = 1'b1;
    step(1);
    letter_ready = 1'b0;
    check(tag, {31'd0, letter_valid}, 32'd0);
  endtask

  task automatic raster(input string tag, input logic [9:0] xv,
                        input logic [9:0] exp_box, input logic [1:0] exp_tap);
    x = xv;
    step(1);
    check({tag, "_box"}, {22'd0, box_x}, {22'd0, exp_box});
    check({tag, "_tap"}, {30'd0, tap}, {30'd0, exp_tap});
  endtask

  initial begin
    int bad;
    rst = 1'b1; key_in = 1'b0; clear = 1'b0; x = 10'd0; letter_ready = 1'b0;
    step(3);
    check("rst_box", {22'd0, box_x}, 32'd20);
    check("rst_valid", {31'd0, letter_valid}, 32'd0);
    rst = 1'b0;
    step(2);

    // 1: reset mid-press discards everything
    key_in = 1'b1;
    step(15);
    rst = 1'b1;
    #1;
    check("t1_valid", {31'd0, letter_valid}, 32'd0);
    check("t1_len", {29'd0, letter_len}, 32'd0);
    check("t1_code", {26'd0, letter_code}, 32'd0);
    check("t1_tap", {30'd0, tap}, 32'd0);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    check("t1_box", {22'd0, box_x}, 32'd20);
    key_in = 1'b0;
    step(5);
    rst = 1'b0;
    step(100);
    check("t1_len_after", {29'd0, letter_len}, 32'd0);
    check("t1_valid_after", {31'd0, letter_valid}, 32'd0);

    // 2: single dot
    press(10, 0);
    wait_valid("t2_valid");
    check("t2_len", {29'd0, letter_len}, 32'd1);
    check("t2_code", {26'd0, letter_code}, 32'd0);
    check("t2_ovf", {31'd0, overflow}, 32'd0);
    handshake("t2_valid_drop");
    check("t2_len_cleared", {29'd0, letter_len}, 32'd0);

    // 3: dash, dot and raster lookup
    press(30, 10);
    press(5, 0);
    wait_valid("t3_valid");
    check("t3_len", {29'd0, letter_len}, 32'd2);
    check("t3_code", {26'd0, letter_code}, 32'd1);
    raster("t3_x47", 10'd47, 10'd45, 2'd2);
    raster("t3_x70", 10'd70, 10'd70, 2'd0);
    raster("t3_x20", 10'd20, 10'd20, 2'd1);
    handshake("t3_valid_drop");

    // 4: seven symbols, last one dropped
    press(30, 8); press(8, 8); press(30, 8); press(8, 8);
    press(8, 8); press(30, 8); press(30, 0);
    wait_valid("t4_valid");
    check("t4_len", {29'd0, letter_len}, 32'd6);
    check("t4_code", {26'd0, letter_code}, 32'h25);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    raster("t4_x169", 10'd169, 10'd145, 2'd1);
    raster("t4_x170", 10'd170, 10'd20, 2'd0);
    raster("t4_x19", 10'd19, 10'd20, 2'd0);
    handshake("t4_valid_drop");
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_ovf_clear", {31'd0, overflow}, 32'd0);

    // 5: glitch rejection, then key activity ignored in COMMIT
    key_in = 1'b1;
    step(2);
    key_in = 1'b0;
    step(100);
    check("t5_glitch_valid", {31'd0, letter_valid}, 32'd0);
    check("t5_glitch_len", {29'd0, letter_len}, 32'd0);
    press(30, 0);
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) press(10, 10);
    check("t5_hold_valid", {31'd0, letter_valid}, 32'd1);
    check("t5_hold_len", {29'd0, letter_len}, 32'd1);
    check("t5_hold_code", {26'd0, letter_code}, 32'd1);
    handshake("t5_valid_drop");
    step(100);
    check("t5_no_relaunch", {31'd0, letter_valid}, 32'd0);

    // 6: clear together with letter_ready
    press(10, 8);
    press(30, 0);
    wait_valid("t6_valid");
    clear = 1'b1;
    letter_ready = 1'b1;
    step(1);
    clear = 1'b0;
    letter_ready = 1'b0;
    check("t6_valid", {31'd0, letter_valid}, 32'd0);
    check("t6_len", {29'd0, letter_len}, 32'd0);
    check("t6_code", {26'd0, letter_code}, 32'd0);
    bad = 0;
    for (int xv = 0; xv < 200; xv++) begin
      x = 10'(xv);
      step(1);
      if (tap !== 2'd0) bad++;
    end
    check("t6_sweep_taps", bad, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
